// File: rtl/dds_waveform_gen.sv
// DDS waveform source for one DAC channel: 32-bit phase accumulator, waveform
// shaping, gain, saturating offset and offset-binary output, 4 cycles phase-to-pin.
module dds_waveform_gen #(
  parameter int PHASE_WIDTH = 32
) (
  input  logic                   clk_250mhz,
  input  logic                   rst_250mhz,
  input  logic                   enable,
  input  logic                   phase_reset,
  input  logic [PHASE_WIDTH-1:0] cfg_ftw,
  input  logic [PHASE_WIDTH-1:0] cfg_phase_ofs,
  input  logic [1:0]             cfg_wave,
  input  logic [15:0]            cfg_amplitude,
  input  logic [15:0]            cfg_offset,
  input  logic [PHASE_WIDTH-1:0] cfg_duty,
  input  logic                   cfg_load,
  input  logic                   cfg_load_sync,
  output logic                   cfg_pending,
  output logic [15:0]            sample_out,
  output logic                   sample_valid,
  output logic                   sync_out
);

  typedef enum logic [1:0] {
    WAVE_DC  = 2'd0,
    WAVE_SAW = 2'd1,
    WAVE_TRI = 2'd2,
    WAVE_SQR = 2'd3
  } wave_e;

  typedef struct packed {
    logic [PHASE_WIDTH-1:0] ftw;
    logic [PHASE_WIDTH-1:0] phase_ofs;
    wave_e                  wave;
    logic [15:0]            amplitude;
    logic [15:0]            offset;
    logic [PHASE_WIDTH-1:0] duty;
  } cfg_t;

  cfg_t w_cfg_in;
  cfg_t r_shadow;
  cfg_t r_active;
  logic r_pending;
  logic r_pend_sync;

  logic [PHASE_WIDTH-1:0] r_phase;
  logic                   r_wrap;
  logic [PHASE_WIDTH-1:0] w_phase_next;
  logic                   w_carry;
  logic                   w_wrap_now;
  logic                   w_apply;

  assign w_cfg_in = '{ftw: cfg_ftw, phase_ofs: cfg_phase_ofs, wave: wave_e'(cfg_wave),
                      amplitude: cfg_amplitude, offset: cfg_offset, duty: cfg_duty};

  assign {w_carry, w_phase_next} = {1'b0, r_phase} + {1'b0, r_active.ftw};
  assign w_wrap_now = enable & ~phase_reset & w_carry;
  // Synchronous loads land on the same edge the accumulator wraps.
  assign w_apply    = r_pending & (~r_pend_sync | w_wrap_now);

  always_ff @(posedge clk_250mhz or posedge rst_250mhz) begin
    if (rst_250mhz) begin
      r_shadow    <= '0;
      r_active    <= '0;
      r_pending   <= 1'b0;
      r_pend_sync <= 1'b0;
    end else begin
      // NOTE: non-blocking, so r_active takes the old shadow even when cfg_load rewrites it on this edge.
      if (w_apply) r_active <= r_shadow;
      if (cfg_load) begin
        r_shadow    <= w_cfg_in;
        r_pending   <= 1'b1;
        r_pend_sync <= cfg_load_sync;
      end else if (w_apply) begin
        r_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_250mhz or posedge rst_250mhz) begin
    if (rst_250mhz) begin
      r_phase <= '0;
      r_wrap  <= 1'b0;
    end else if (phase_reset) begin
      r_phase <= '0;
      r_wrap  <= 1'b0;
    end else if (enable) begin
      r_phase <= w_phase_next;
      r_wrap  <= w_carry;
    end
  end

  logic [PHASE_WIDTH-1:0] w_p;
  logic [15:0]            w_u;
  logic [15:0]            w_tri;
  logic signed [15:0]     w_wave_s;

  assign w_p   = r_phase + r_active.phase_ofs;
  assign w_u   = w_p[PHASE_WIDTH-1 -: 16];
  assign w_tri = w_u[15] ? ~{w_u[14:0], 1'b0} : {w_u[14:0], 1'b0};

  always_comb begin
    // NOTE: default first so every path assigns and no latch is inferred.
    w_wave_s = '0;
    case (r_active.wave)
      WAVE_SAW: w_wave_s = w_u - 16'h8000;
      WAVE_TRI: w_wave_s = w_tri - 16'h8000;
      WAVE_SQR: w_wave_s = (w_p < r_active.duty) ? 16'h7FFF : 16'h8000;
      default:  w_wave_s = '0;
    endcase
  end

  logic signed [15:0] r_s2;
  logic signed [15:0] r_g3;
  logic [15:0]        r_v4;
  logic [15:0]        r_sample;
  logic               r_valid2, r_valid3, r_valid4, r_valid5;
  logic               r_sync2, r_sync3, r_sync4, r_sync5;

  logic signed [32:0] w_s_ext;
  logic signed [32:0] w_amp_ext;
  logic signed [32:0] w_prod;
  logic signed [17:0] w_sum;
  logic [15:0]        w_sat;

  // Amplitude is unsigned, so it is zero-extended before the signed multiply.
  assign w_s_ext   = 33'(r_s2);
  assign w_amp_ext = {17'd0, r_active.amplitude};
  assign w_prod    = w_s_ext * w_amp_ext;
  assign w_sum     = 18'(r_g3) + 18'($signed(r_active.offset));

  always_comb begin
    w_sat = w_sum[15:0];
    if (w_sum > 18'sd32767)       w_sat = 16'h7FFF;
    else if (w_sum < -18'sd32768) w_sat = 16'h8000;
  end

  always_ff @(posedge clk_250mhz or posedge rst_250mhz) begin
    if (rst_250mhz) begin
      r_s2     <= '0;
      r_g3     <= '0;
      r_v4     <= '0;
      r_sample <= 16'h8000;
      {r_valid2, r_valid3, r_valid4, r_valid5} <= '0;
      {r_sync2, r_sync3, r_sync4, r_sync5}     <= '0;
    end else begin
      r_s2     <= w_wave_s;
      r_valid2 <= enable;
      r_sync2  <= enable & r_wrap;
      r_g3     <= 16'(w_prod >>> 16);
      r_valid3 <= r_valid2;
      r_sync3  <= r_sync2;
      r_v4     <= w_sat;
      r_valid4 <= r_valid3;
      r_sync4  <= r_sync3;
      r_sample <= r_v4 ^ 16'h8000;
      r_valid5 <= r_valid4;
      r_sync5  <= r_sync4;
    end
  end

  assign cfg_pending  = r_pending;
  assign sample_out   = r_sample;
  assign sample_valid = r_valid5;
  assign sync_out     = r_sync5;

endmodule

// File: tb/tb_dds_waveform_gen.sv
// Directed bench for dds_waveform_gen: inputs change and outputs are checked on the
// falling clock edge, so every posedge sees stable stimulus.
module tb_dds_waveform_gen;

  logic        clk_250mhz    = 1'b0;
  logic        rst_250mhz    = 1'b1;
  logic        enable        = 1'b0;
  logic        phase_reset   = 1'b0;
  logic [31:0] cfg_ftw       = '0;
  logic [31:0] cfg_phase_ofs = '0;
  logic [1:0]  cfg_wave      = '0;
  logic [15:0] cfg_amplitude = '0;
  logic [15:0] cfg_offset    = '0;
  logic [31:0] cfg_duty      = '0;
  logic        cfg_load      = 1'b0;
  logic        cfg_load_sync = 1'b0;
  logic        cfg_pending;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        sync_out;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_s;
  logic        exp_b;
  int          idx;

  dds_waveform_gen dut (
    .clk_250mhz   (clk_250mhz),
    .rst_250mhz   (rst_250mhz),
    .enable       (enable),
    .phase_reset  (phase_reset),
    .cfg_ftw      (cfg_ftw),
    .cfg_phase_ofs(cfg_phase_ofs),
    .cfg_wave     (cfg_wave),
    .cfg_amplitude(cfg_amplitude),
    .cfg_offset   (cfg_offset),
    .cfg_duty     (cfg_duty),
    .cfg_load     (cfg_load),
    .cfg_load_sync(cfg_load_sync),
    .cfg_pending  (cfg_pending),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .sync_out     (sync_out)
  );

  always #2 clk_250mhz = ~clk_250mhz;

  task automatic step(input int n);
    repeat (n) @(negedge clk_250mhz);
  endtask

  task automatic start_zero();
    enable      = 1'b0;
    phase_reset = 1'b1;
    step(1);
    phase_reset = 1'b0;
  endtask

  // Immediate load; active config is in place when the task returns.
  task automatic load_cfg(input logic [31:0] ftw, input logic [31:0] ofs, input logic [1:0] wave,
                          input logic [15:0] amp, input logic [15:0] off, input logic [31:0] duty);
    cfg_ftw = ftw; cfg_phase_ofs = ofs; cfg_wave = wave;
    cfg_amplitude = amp; cfg_offset = off; cfg_duty = duty;
    cfg_load_sync = 1'b0;
    cfg_load = 1'b1;
    step(1);
    cfg_load = 1'b0;
    step(1);
  endtask

  // Phase index (units of 2^24) seen at sample m in test_cfg_sync.
  function automatic int t4_idx(input int m);
    if (m <= 256)      return m % 256;
    else if (m <= 306) return (2 * (m - 256)) % 256;
    else               return (100 + (m - 306)) % 256;
  endfunction

  task automatic test_reset();
    rst_250mhz = 1'b1;
    step(3);
    checks++; if (sample_out !== 16'h8000) begin errors++; $display("FAIL reset_sample got %h want 8000", sample_out); end
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", sample_valid); end
    checks++; if (sync_out !== 1'b0) begin errors++; $display("FAIL reset_sync got %b want 0", sync_out); end
    checks++; if (cfg_pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %b want 0", cfg_pending); end
    rst_250mhz = 1'b0;
    step(1);
  endtask

  task automatic test_saw();
    load_cfg(32'h0100_0000, 32'h0, 2'd1, 16'h8000, 16'h0000, 32'h0);
    enable = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step(1);
      checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL saw_latency cyc=%0d got %b want 0", i, sample_valid); end
    end
    step(1);
    for (int m = 0; m <= 512; m++) begin
      exp_s = 16'h4000 + 16'((m % 256) * 128);
      exp_b = (m != 0) && (m % 256 == 0);
      checks++; if (sample_out !== exp_s) begin errors++; $display("FAIL saw_sample m=%0d got %h want %h", m, sample_out, exp_s); end
      checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL saw_valid m=%0d got %b want 1", m, sample_valid); end
      checks++; if (sync_out !== exp_b) begin errors++; $display("FAIL saw_sync m=%0d got %b want %b", m, sync_out, exp_b); end
      step(1);
    end
  endtask

  task automatic test_square(input logic [15:0] off, input logic [15:0] exp_hi, input logic [15:0] exp_lo);
    start_zero();
    load_cfg(32'h1000_0000, 32'h0, 2'd3, 16'hFFFF, off, 32'h8000_0000);
    enable = 1'b1;
    step(4);
    for (int m = 0; m < 34; m++) begin
      exp_s = ((m % 16) < 8) ? exp_hi : exp_lo;
      exp_b = (m == 16) || (m == 32);
      checks++; if (sample_out !== exp_s) begin errors++; $display("FAIL square_sample ofs=%h m=%0d got %h want %h", off, m, sample_out, exp_s); end
      checks++; if (sync_out !== exp_b) begin errors++; $display("FAIL square_sync ofs=%h m=%0d got %b want %b", off, m, sync_out, exp_b); end
      step(1);
    end
  endtask

  task automatic test_cfg_sync();
    start_zero();
    load_cfg(32'h0100_0000, 32'h0, 2'd1, 16'h8000, 16'h0000, 32'h0);
    enable = 1'b1;
    step(4);
    for (int m = 0; m <= 400; m++) begin
      idx   = t4_idx(m);
      exp_s = 16'h4000 + 16'(idx * 128);
      checks++; if (sample_out !== exp_s) begin errors++; $display("FAIL cfgsync_sample m=%0d got %h want %h", m, sample_out, exp_s); end
      exp_b = (m == 256);
      checks++; if (sync_out !== exp_b) begin errors++; $display("FAIL cfgsync_sync m=%0d got %b want %b", m, sync_out, exp_b); end
      exp_b = (m >= 101 && m <= 251) || (m == 301);
      checks++; if (cfg_pending !== exp_b) begin errors++; $display("FAIL cfgsync_pending m=%0d got %b want %b", m, cfg_pending, exp_b); end
      if (m == 100) begin cfg_ftw = 32'h0200_0000; cfg_load_sync = 1'b1; cfg_load = 1'b1; end
      if (m == 300) begin cfg_ftw = 32'h0100_0000; cfg_load_sync = 1'b0; cfg_load = 1'b1; end
      if (m == 101 || m == 301) cfg_load = 1'b0;
      step(1);
    end
  endtask

  task automatic test_phase_reset();
    start_zero();
    load_cfg(32'h0100_0000, 32'h0, 2'd1, 16'h8000, 16'h0000, 32'h0);
    enable = 1'b1;
    step(100);
    // Accumulator holds index 100 here; reset it while enable stays high.
    phase_reset = 1'b1;
    step(1);
    phase_reset = 1'b0;
    step(3);
    checks++; if (sample_out !== 16'h7200) begin errors++; $display("FAIL preset_before got %h want 7200", sample_out); end
    step(1);
    checks++; if (sample_out !== 16'h4000) begin errors++; $display("FAIL preset_zero got %h want 4000", sample_out); end
    checks++; if (sync_out !== 1'b0) begin errors++; $display("FAIL preset_sync got %b want 0", sync_out); end
    step(251);
    // Accumulator at index 255: a reset here must not look like a wrap.
    phase_reset = 1'b1;
    step(1);
    phase_reset = 1'b0;
    step(3);
    checks++; if (sample_out !== 16'hBF80) begin errors++; $display("FAIL preset_last got %h want bf80", sample_out); end
    step(1);
    checks++; if (sample_out !== 16'h4000) begin errors++; $display("FAIL preset_wrapzero got %h want 4000", sample_out); end
    checks++; if (sync_out !== 1'b0) begin errors++; $display("FAIL preset_wrapsync got %b want 0", sync_out); end
    step(1);
    checks++; if (sample_out !== 16'h4080) begin errors++; $display("FAIL preset_next got %h want 4080", sample_out); end
  endtask

  task automatic test_enable_hold();
    start_zero();
    load_cfg(32'h0100_0000, 32'h0, 2'd1, 16'h8000, 16'h0000, 32'h0);
    enable = 1'b1;
    step(256);
    // Accumulator has just wrapped to 0; stop before that phase is consumed.
    enable = 1'b0;
    step(4);
    for (int i = 0; i < 5; i++) begin
      checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL hold_valid i=%0d got %b want 0", i, sample_valid); end
      checks++; if (sync_out !== 1'b0) begin errors++; $display("FAIL hold_sync i=%0d got %b want 0", i, sync_out); end
      checks++; if (sample_out !== 16'h4000) begin errors++; $display("FAIL hold_sample i=%0d got %h want 4000", i, sample_out); end
      step(1);
    end
    enable = 1'b1;
    step(4);
    checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL hold_resume_valid got %b want 1", sample_valid); end
    checks++; if (sample_out !== 16'h4000) begin errors++; $display("FAIL hold_resume_sample got %h want 4000", sample_out); end
    step(1);
    checks++; if (sample_out !== 16'h4080) begin errors++; $display("FAIL hold_resume_next got %h want 4080", sample_out); end
  endtask

  task automatic test_async_reset();
    start_zero();
    load_cfg(32'h0100_0000, 32'h0, 2'd1, 16'h8000, 16'h0000, 32'h0);
    enable = 1'b1;
    step(20);
    cfg_ftw = 32'h0300_0000; cfg_load_sync = 1'b1; cfg_load = 1'b1;
    step(1);
    cfg_load = 1'b0;
    checks++; if (cfg_pending !== 1'b1) begin errors++; $display("FAIL areset_pre_pending got %b want 1", cfg_pending); end
    step(3);
    rst_250mhz = 1'b1;
    #1;
    checks++; if (sample_out !== 16'h8000) begin errors++; $display("FAIL areset_sample got %h want 8000", sample_out); end
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %b want 0", sample_valid); end
    checks++; if (sync_out !== 1'b0) begin errors++; $display("FAIL areset_sync got %b want 0", sync_out); end
    checks++; if (cfg_pending !== 1'b0) begin errors++; $display("FAIL areset_pending got %b want 0", cfg_pending); end
    step(2);
    rst_250mhz = 1'b0;
    step(6);
    checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL areset_post_valid got %b want 1", sample_valid); end
    checks++; if (sample_out !== 16'h8000) begin errors++; $display("FAIL areset_post_sample got %h want 8000", sample_out); end
    checks++; if (cfg_pending !== 1'b0) begin errors++; $display("FAIL areset_post_pending got %b want 0", cfg_pending); end
  endtask

  initial begin
    test_reset();
    test_saw();
    test_square(16'h0000, 16'hFFFE, 16'h0000);
    test_square(16'h4000, 16'hFFFF, 16'h4000);
    test_cfg_sync();
    test_phase_reset();
    test_enable_hold();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
